// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default timing constants.
// The receive path imports this package as well.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BIT  = 2'd2,
    STOP_BIT  = 2'd3
  } txState_e;

endpackage

// File: rtl/uart_tx_frame.sv
// Single-byte 8N1 serialiser. A load during the final stop-bit cycle chains the
// next frame's start bit directly, so consecutive frames have no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 frameDone
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  txState_e             state, stateNext;
  logic [CNT_W-1:0]     cycleCnt, cycleCntNext;
  logic [BIT_W-1:0]     bitIdx, bitIdxNext;
  logic [DATA_BITS-1:0] dataReg, dataRegNext;
  logic                 txNext;
  logic                 bitEnd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cycleCnt <= '0;
      bitIdx   <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= stateNext;
      cycleCnt <= cycleCntNext;
      bitIdx   <= bitIdxNext;
      tx       <= txNext;
    end
  end

  always_ff @(posedge clock) begin
    dataReg <= dataRegNext;
  end

  // tx is computed from the next state so the line comes straight from a flop.
  always_comb begin
    stateNext    = state;
    cycleCntNext = cycleCnt;
    bitIdxNext   = bitIdx;
    dataRegNext  = dataReg;
    txNext       = 1'b1;
    bitEnd       = (cycleCnt == CNT_LAST);
    frameDone    = (state == STOP_BIT) && bitEnd;

    if (state != IDLE) begin
      cycleCntNext = bitEnd ? '0 : cycleCnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (load) begin
          stateNext    = START_BIT;
          cycleCntNext = '0;
          dataRegNext  = data;
        end
      end
      START_BIT: begin
        if (bitEnd) begin
          stateNext  = DATA_BIT;
          bitIdxNext = '0;
        end
      end
      DATA_BIT: begin
        if (bitEnd) begin
          if (bitIdx == BIT_LAST) begin
            stateNext = STOP_BIT;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end
      end
      STOP_BIT: begin
        if (bitEnd) begin
          if (load) begin
            stateNext   = START_BIT;
            dataRegNext = data;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    case (stateNext)
      START_BIT: txNext = 1'b0;
      DATA_BIT:  txNext = dataRegNext[bitIdxNext];
      default:   txNext = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/uart_tx_two_byte.sv
// Two-byte UART transmitter: latches a byte pair on start and sends both as
// back-to-back 8N1 frames, pulsing done when the second stop bit ends.
module uart_tx_two_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] first_byte,
  input  logic [DATA_BITS-1:0] second_byte,
  output logic                 busy,
  output logic                 tx,
  output logic                 done
);

  logic                 byteIdx;
  logic [DATA_BITS-1:0] secondByteReg;
  logic                 frameLoad;
  logic [DATA_BITS-1:0] frameData;
  logic                 frameBusy;
  logic                 frameDone;

  // The first byte goes straight into the serialiser on acceptance; only the
  // second byte needs holding until the first frame's stop bit finishes.
  always_comb begin
    frameLoad = 1'b0;
    frameData = first_byte;
    if (!frameBusy) begin
      frameLoad = start;
    end else if (frameDone && !byteIdx) begin
      frameLoad = 1'b1;
      frameData = secondByteReg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byteIdx <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= frameDone && byteIdx;
      if (!frameBusy && start) begin
        byteIdx       <= 1'b0;
        secondByteReg <= second_byte;
      end else if (frameDone && !byteIdx) begin
        byteIdx <= 1'b1;
      end
    end
  end

  uart_tx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) frameTx (
    .clock    (clock),
    .reset    (reset),
    .load     (frameLoad),
    .data     (frameData),
    .tx       (tx),
    .busy     (frameBusy),
    .frameDone(frameDone)
  );

  assign busy = frameBusy;

endmodule

// File: tb/tb_uart_tx_two_byte.sv
// Self-checking bench for uart_tx_two_byte: a bit-level waveform model plus an
// independent line receiver, at 4 and 434 clocks per bit.
module tb_uart_tx_two_byte;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] firstByte;
  logic [7:0] secondByte;
  logic       busy;
  logic       tx;
  logic       done;
  logic       start434;
  logic [7:0] first434;
  logic [7:0] second434;
  logic       busy434;
  logic       tx434;
  logic       done434;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] rxQ4[$];
  logic [7:0] rxQ434[$];
  int         rxBad4   = 0;
  int         rxBad434 = 0;

  uart_tx_two_byte #(.CLKS_PER_BIT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .first_byte (firstByte),
    .second_byte(secondByte),
    .busy       (busy),
    .tx         (tx),
    .done       (done)
  );

  uart_tx_two_byte #(.CLKS_PER_BIT(434)) dut434 (
    .clock      (clock),
    .reset      (reset),
    .start      (start434),
    .first_byte (first434),
    .second_byte(second434),
    .busy       (busy434),
    .tx         (tx434),
    .done       (done434)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected line level for bit slot n of a transfer: 10 slots per frame.
  function automatic logic expTx(input logic [7:0] b0, input logic [7:0] b1, input int n);
    int f;
    int p;
    logic [7:0] b;
    f = n / 10;
    p = n % 10;
    b = (f == 0) ? b0 : b1;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  // Mid-bit sampling receiver, independent of the transmitter's internals.
  task automatic rxLoop(input int clks, input bit slow);
    logic prevTx;
    logic cur;
    logic [7:0] data;
    bit ok;
    prevTx = 1'b1;
    forever begin
      @(negedge clock);
      cur = slow ? tx434 : tx;
      if (prevTx === 1'b1 && cur === 1'b0) begin
        repeat (clks / 2) @(negedge clock);
        ok = ((slow ? tx434 : tx) === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (clks) @(negedge clock);
          data[i] = slow ? tx434 : tx;
        end
        repeat (clks) @(negedge clock);
        ok = ok && ((slow ? tx434 : tx) === 1'b1);
        if (slow) begin
          rxQ434.push_back(data);
          if (!ok) rxBad434++;
        end else begin
          rxQ4.push_back(data);
          if (!ok) rxBad4++;
        end
        cur = 1'b1;
      end
      prevTx = cur;
    end
  endtask

  initial rxLoop(4, 1'b0);
  initial rxLoop(434, 1'b1);

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    firstByte = 8'h00;
    secondByte = 8'h00;
    start434 = 1'b0;
    first434 = 8'h00;
    second434 = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      assertCount++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx434 !== 1'b1 || busy434 !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_idle cycle %0d: tx=%b busy=%b done=%b tx434=%b busy434=%b, required 1 0 0 1 0",
                 i, tx, busy, done, tx434, busy434);
      end
    end
  endtask

  task automatic test_known_pattern();
    int busyCycles;
    busyCycles = 0;
    firstByte = 8'hA5;
    secondByte = 8'h3C;
    start = 1'b1;
    for (int k = 0; k < 82; k++) begin
      @(negedge clock);
      if (k == 0) start = 1'b0;
      if (busy === 1'b1) busyCycles++;
      assertCount++;
      if (k < 80) begin
        if (tx !== expTx(8'hA5, 8'h3C, k / 4) || busy !== 1'b1 || done !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL pattern cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                   k, tx, busy, done, expTx(8'hA5, 8'h3C, k / 4));
        end
      end else if (k == 80) begin
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL pattern_done: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1", tx, busy, done);
        end
      end else begin
        if (busy !== 1'b0 || done !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL pattern_after: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
      end
    end
    assertCount++;
    if (busyCycles != 80) begin
      failCount++;
      $display("[TB] FAIL pattern_busy_len: got %0d cycles, required 80", busyCycles);
    end
  endtask

  task automatic test_ignore_start();
    int doneCount;
    int busyAfter;
    doneCount = 0;
    busyAfter = 0;
    firstByte = 8'hA5;
    secondByte = 8'h3C;
    start = 1'b1;
    for (int k = 0; k < 95; k++) begin
      @(negedge clock);
      if (k >= 1 && k <= 70) begin
        start = 1'($urandom_range(0, 1));
        firstByte = 8'hFF;
        secondByte = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) doneCount++;
      if (k >= 80 && busy !== 1'b0) busyAfter++;
      if (k < 80) begin
        assertCount++;
        if (tx !== expTx(8'hA5, 8'h3C, k / 4)) begin
          failCount++;
          $display("[TB] FAIL ignore_tx cycle %0d: tx=%b, required %b", k, tx, expTx(8'hA5, 8'h3C, k / 4));
        end
      end
    end
    assertCount++;
    if (doneCount != 1) begin
      failCount++;
      $display("[TB] FAIL ignore_done_count: got %0d, required 1", doneCount);
    end
    assertCount++;
    if (busyAfter != 0) begin
      failCount++;
      $display("[TB] FAIL ignore_no_restart: busy high %0d cycles after done, required 0", busyAfter);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] n1;
    logic [7:0] n2;
    int busyLow;
    logic expT;
    n1 = 8'($urandom);
    n2 = 8'($urandom);
    busyLow = 0;
    firstByte = 8'h00;
    secondByte = 8'hFF;
    start = 1'b1;
    for (int k = 0; k < 163; k++) begin
      @(negedge clock);
      if (k == 80) begin
        firstByte = n1;
        secondByte = n2;
      end
      if (k == 81) start = 1'b0;
      if (k < 161 && busy !== 1'b1) busyLow++;
      assertCount++;
      if (k == 80 || k == 161) begin
        if (busy !== 1'b0 || done !== 1'b1 || tx !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL b2b_done cycle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1", k, tx, busy, done);
        end
      end else if (k == 162) begin
        if (busy !== 1'b0 || done !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL b2b_end: busy=%b done=%b, required 0 0", busy, done);
        end
      end else begin
        expT = (k < 80) ? expTx(8'h00, 8'hFF, k / 4) : expTx(n1, n2, (k - 81) / 4);
        if (tx !== expT || busy !== 1'b1 || done !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL b2b cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0", k, tx, busy, done, expT);
        end
      end
    end
    assertCount++;
    if (busyLow != 1) begin
      failCount++;
      $display("[TB] FAIL b2b_gap: busy low %0d cycles between transfers, required 1", busyLow);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r1;
    logic [7:0] r2;
    int doneCount;
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    doneCount = 0;
    firstByte = r1;
    secondByte = r2;
    start = 1'b1;
    for (int k = 0; k <= 56; k++) begin
      @(negedge clock);
      start = 1'b0;
      assertCount++;
      if (tx !== expTx(r1, r2, k / 4)) begin
        failCount++;
        $display("[TB] FAIL abort_pre_tx cycle %0d: tx=%b, required %b", k, tx, expTx(r1, r2, k / 4));
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    assertCount++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_state: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) doneCount++;
    end
    assertCount++;
    if (doneCount != 0) begin
      failCount++;
      $display("[TB] FAIL abort_quiet: %0d cycles with busy/done high, required 0", doneCount);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    assertCount++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_beats_start: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    end
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    firstByte = r1;
    secondByte = r2;
    start = 1'b1;
    for (int k = 0; k < 81; k++) begin
      @(negedge clock);
      start = 1'b0;
      assertCount++;
      if (k < 80) begin
        if (tx !== expTx(r1, r2, k / 4) || busy !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL clean_tx cycle %0d: tx=%b busy=%b, required tx=%b busy=1", k, tx, busy, expTx(r1, r2, k / 4));
        end
      end else if (done !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL clean_done: done=%b, required 1", done);
      end
    end
  endtask

  task automatic test_random_rx();
    logic [7:0] expQ4[$];
    logic [7:0] expQ434[$];
    logic [7:0] a;
    logic [7:0] b;
    int cnt;
    repeat (60) @(negedge clock);
    rxQ4.delete();
    rxQ434.delete();
    rxBad4 = 0;
    rxBad434 = 0;
    for (int i = 0; i < 50; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      firstByte = a;
      secondByte = b;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      expQ4.push_back(a);
      expQ4.push_back(b);
      cnt = 0;
      while (done !== 1'b1 && cnt < 100) begin
        @(negedge clock);
        cnt++;
      end
      assertCount++;
      if (done !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL rx4_timeout pair %0d: done=%b after %0d cycles, required 1", i, done, cnt);
      end
    end
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      first434 = a;
      second434 = b;
      start434 = 1'b1;
      @(negedge clock);
      start434 = 1'b0;
      expQ434.push_back(a);
      expQ434.push_back(b);
      cnt = 0;
      while (done434 !== 1'b1 && cnt < 20 * 434 + 50) begin
        @(negedge clock);
        cnt++;
      end
      assertCount++;
      if (done434 !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL rx434_timeout pair %0d: done=%b after %0d cycles, required 1", i, done434, cnt);
      end
    end
    repeat (20) @(negedge clock);
    assertCount++;
    if (rxQ4.size() != expQ4.size() || rxBad4 != 0) begin
      failCount++;
      $display("[TB] FAIL rx4_count: got %0d bytes (%0d framing errors), required %0d bytes, 0 errors",
               rxQ4.size(), rxBad4, expQ4.size());
    end
    for (int i = 0; i < expQ4.size() && i < rxQ4.size(); i++) begin
      assertCount++;
      if (rxQ4[i] !== expQ4[i]) begin
        failCount++;
        $display("[TB] FAIL rx4_byte %0d: got %h, required %h", i, rxQ4[i], expQ4[i]);
      end
    end
    assertCount++;
    if (rxQ434.size() != expQ434.size() || rxBad434 != 0) begin
      failCount++;
      $display("[TB] FAIL rx434_count: got %0d bytes (%0d framing errors), required %0d bytes, 0 errors",
               rxQ434.size(), rxBad434, expQ434.size());
    end
    for (int i = 0; i < expQ434.size() && i < rxQ434.size(); i++) begin
      assertCount++;
      if (rxQ434[i] !== expQ434[i]) begin
        failCount++;
        $display("[TB] FAIL rx434_byte %0d: got %h, required %h", i, rxQ434[i], expQ434[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_pattern();
    repeat (5) @(negedge clock);
    test_ignore_start();
    test_back_to_back();
    repeat (5) @(negedge clock);
    test_reset_mid();
    test_random_rx();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
